// File: rtl/alu_issue_pkg.sv
// Shared types and field layout for the ALU issue controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_issue_pkg;

    // Instruction field bit positions
    localparam int LD_BIT  = 15;
    localparam int OP_MSB  = 14;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS1_MSB = 9;
    localparam int RS1_LSB = 8;
    localparam int RS2_MSB = 7;
    localparam int RS2_LSB = 6;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        OP_NOT  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_AND  = 3'd3,
        OP_MUL4 = 3'd4,
        OP_ADD  = 3'd5,
        OP_MUL8 = 3'd6,
        OP_SUB  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_e;

    // Instruction word view; imm8 overlaps rs2 and the reserved bits
    typedef struct packed {
        logic       ld;
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic [5:0] rsvd;
    } instr_t;

    function automatic logic [7:0] imm8(input logic [15:0] w);
        return w[IMM_MSB:IMM_LSB];
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Small register file: one write port, three combinational read ports.
// Latency: write visible on reads the cycle after the writing edge, no bypass.
// Backpressure: none; writes are accepted every cycle wr_en is high.
module alu_issue_regfile #(
    parameter int NREGS = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [1:0]    wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic [1:0]    rs1_addr,
    input  logic [1:0]    rs2_addr,
    input  logic [1:0]    dbg_addr,
    output logic [DW-1:0] rs1_dat,
    output logic [DW-1:0] rs2_dat,
    output logic [DW-1:0] dbg_dat
);

    logic [DW-1:0] rf [NREGS];

    // Storage: cleared by reset, single write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_en) begin
            rf[wr_addr] <= wr_dat;
        end
    end

    assign rs1_dat = rf[rs1_addr];
    assign rs2_dat = rf[rs2_addr];
    assign dbg_dat = rf[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Serialised issue front end for an external combinational 8-bit ALU.
// Latency: accept -> res_valid is 2 cycles; one instruction every 3 cycles.
// Backpressure: instr_ready only in IDLE; source holds instr_valid/instr until accepted.
module alu_issue_ctrl #(
    parameter int NREGS = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    input  logic [15:0]   instr,
    output logic          instr_ready,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_opcode,
    input  logic [DW-1:0] alu_out,
    output logic          res_valid,
    output logic [1:0]    res_rd,
    output logic [DW-1:0] res_data,
    input  logic [1:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    import alu_issue_pkg::*;

    state_e        state_q, state_d;
    instr_t        iw;
    logic          accept;
    logic          wr_en;
    logic          ld_q;
    logic [1:0]    rd_q;
    logic [7:0]    imm_q;
    logic [DW-1:0] rs1_dat, rs2_dat, wb_dat;

    assign iw          = instr_t'(instr);
    assign instr_ready = (state_q == IDLE);
    assign res_valid   = (state_q == WB);
    assign accept      = instr_ready && instr_valid;
    assign wr_en       = (state_q == ISSUE);
    assign wb_dat      = ld_q ? DW'(imm_q) : alu_out;

    alu_issue_regfile #(.NREGS(NREGS), .DW(DW)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (rd_q),
        .wr_dat   (wb_dat),
        .rs1_addr (iw.rs1),
        .rs2_addr (iw.rs2),
        .dbg_addr (dbg_addr),
        .rs1_dat  (rs1_dat),
        .rs2_dat  (rs2_dat),
        .dbg_dat  (dbg_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; unlisted encodings fall back to IDLE via the default assignment
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:  state_d = instr_valid ? ISSUE : IDLE;
            ISSUE: state_d = WB;
            WB:    state_d = IDLE;
        endcase
    end

    // Operand/opcode capture on accept; write-back result capture during ISSUE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            ld_q       <= 1'b0;
            rd_q       <= '0;
            imm_q      <= '0;
            res_rd     <= '0;
            res_data   <= '0;
        end else begin
            if (accept) begin
                alu_a      <= rs1_dat;
                alu_b      <= rs2_dat;
                alu_opcode <= iw.op;
                ld_q       <= iw.ld;
                rd_q       <= iw.rd;
                imm_q      <= imm8(instr);
            end
            if (wr_en) begin
                res_rd   <= rd_q;
                res_data <= wb_dat;
            end
        end
    end

endmodule
